// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for a register bank: picks one pending requester, drives a one-cycle write.
// Build option REGARB_FIXED_PRIO_EN: lowest index always wins and no rotating pointer exists.
module regbank_write_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREG-1:0]      chosen,
  output logic                 w_en,
  output logic [DW-1:0]        w_data,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e          state_q;
  logic [NREQ-1:0] ack_q;
  logic [NREG-1:0] chosen_q;
  logic            w_en_q;
  logic [DW-1:0]   w_data_q;
  logic            busy_q;
  logic            err_q;

  logic [IW-1:0]   win_id;
  logic            win_vld;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            addr_ok;
  int unsigned     base;
  int unsigned     idx;

`ifndef REGARB_FIXED_PRIO_EN
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   id_q;
`endif

  // Scan starting at base; the first requester found wins.
  always_comb begin
    win_id   = '0;
    win_vld  = 1'b0;
    win_addr = '0;
    win_data = '0;
    idx      = 0;
`ifdef REGARB_FIXED_PRIO_EN
    base     = 0;
`else
    base     = 32'(ptr_q);
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (base + k) % NREQ;
      if (req[idx] && !win_vld) begin
        win_vld  = 1'b1;
        win_id   = IW'(idx);
        win_addr = req_addr[idx*AW +: AW];
        win_data = req_data[idx*DW +: DW];
      end
    end
    addr_ok = 32'(win_addr) < NREG;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ack_q    <= '0;
      chosen_q <= '0;
      w_en_q   <= 1'b0;
      w_data_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
      ptr_q    <= '0;
      id_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q  <= StWrite;
            ack_q    <= NREQ'(1) << win_id;
            w_data_q <= win_data;
            busy_q   <= 1'b1;
            w_en_q   <= addr_ok;
            // Out-of-range address: acknowledge but suppress the bank write.
            chosen_q <= addr_ok ? (NREG'(1) << win_addr) : '0;
            err_q    <= !addr_ok;
`ifndef REGARB_FIXED_PRIO_EN
            id_q     <= win_id;
`endif
          end
        end
        StWrite: begin
          state_q  <= StIdle;
          ack_q    <= '0;
          chosen_q <= '0;
          w_en_q   <= 1'b0;
          w_data_q <= '0;
          busy_q   <= 1'b0;
          err_q    <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
          ptr_q    <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack    = ack_q;
  assign chosen = chosen_q;
  assign w_en   = w_en_q;
  assign w_data = w_data_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter (NREG=6 so address 7 is out of range).
module tb_regbank_write_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 6;
  localparam int unsigned AW   = 3;
  localparam int unsigned DW   = 6;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]  ack;
  logic [NREG-1:0]  chosen;
  logic             w_en;
  logic [DW-1:0]    w_data;
  logic             busy;
  logic             err;

  regbank_write_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .chosen(chosen), .w_en(w_en), .w_data(w_data), .busy(busy), .err(err)
  );

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] ack;
    logic [NREG-1:0] chosen;
    logic            w_en;
    logic [DW-1:0]   w_data;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   addrs[NREQ] = '{0, 7, 5, 3};
  int   datas[NREQ] = '{'h11, 'h22, 'h2A, 'h3C};

`ifdef REGARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t mk(int id, int at);
    exp_t e;
    e.cyc    = at;
    e.ack    = NREQ'(1) << id;
    e.w_data = DW'(datas[id]);
    if (addrs[id] < int'(NREG)) begin
      e.w_en = 1'b1; e.chosen = NREG'(1) << addrs[id]; e.err = 1'b0;
    end else begin
      e.w_en = 1'b0; e.chosen = '0; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on every busy cycle, otherwise outputs must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      vecs++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write cyc=%0d got ack=%b chosen=%b, want no write", cyc, ack,
                 chosen);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || ack !== e.ack || chosen !== e.chosen || w_en !== e.w_en ||
            w_data !== e.w_data || err !== e.err) begin
          miscompares++;
          $display("FAIL write cyc=%0d ack=%b chosen=%b w_en=%b w_data=%h err=%b; want cyc=%0d ack=%b chosen=%b w_en=%b w_data=%h err=%b",
                   cyc, ack, chosen, w_en, w_data, err,
                   e.cyc, e.ack, e.chosen, e.w_en, e.w_data, e.err);
        end
      end
    end else begin
      vecs++;
      if (ack !== '0 || chosen !== '0 || w_en !== 1'b0 || w_data !== '0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet cyc=%0d ack=%b chosen=%b w_en=%b w_data=%h err=%b; want all 0",
                 cyc, ack, chosen, w_en, w_data, err);
      end
    end
  end

  initial begin
    int base;
    rst      = 1'b0;
    req      = 4'b1111;
    req_addr = {3'd3, 3'd5, 3'd7, 3'd0};
    req_data = {6'h3C, 6'h2A, 6'h22, 6'h11};
    repeat (3) tick();

    // Release reset with everyone requesting: 0,1,2,3,0 in round-robin.
    rst  = 1'b1;
    base = cyc;
    for (int k = 0; k < 5; k++) sb.push_back(mk(FIXED ? 0 : k % 4, base + 1 + 2 * k));
    repeat (9) tick();
    req = '0;
    repeat (2) tick();

    // Single write, requester 2 -> addr 5.
    req = 4'b0100;
    sb.push_back(mk(2, cyc + 1));
    tick();
    req = '0;
    repeat (2) tick();

    // Bad address from requester 1, then pointer must sit at 2.
    req = 4'b0010;
    sb.push_back(mk(1, cyc + 1));
    tick();
    req = '0;
    tick();
    req = 4'b1010;
    sb.push_back(mk(FIXED ? 1 : 3, cyc + 1));
    tick();
    req = '0;
    repeat (2) tick();

    // Reset during the write cycle kills it immediately.
    req = 4'b0100;
    tick();
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (w_en !== 1'b0 || chosen !== '0 || ack !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset w_en=%b chosen=%b ack=%b busy=%b; want all 0",
               w_en, chosen, ack, busy);
    end
    repeat (2) tick();
    rst = 1'b1;
    sb.push_back(mk(2, cyc + 1));
    tick();
    req = '0;
    repeat (2) tick();

    // Requester 3 rises while requester 1 is being written.
    req = 4'b0010;
    sb.push_back(mk(1, cyc + 1));
    tick();
    req = 4'b1000;
    sb.push_back(mk(3, cyc + 2));
    repeat (2) tick();
    req = '0;
    repeat (3) tick();

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vecs++;
      miscompares++;
      $display("FAIL missing_write got none, want ack=%b at cyc=%0d", e.ack, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
